// File: rtl/ahb_arb_pkg.sv
// Shared encodings for the two-master AHB arbiter: FSM states, master IDs and htrans values.
package ahb_arb_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      OWN1 = 2'b01,
      OWN2 = 2'b10
   } arb_state_e;

   localparam logic M1 = 1'b0;
   localparam logic M2 = 1'b1;

   localparam logic HTRANS_IDLE   = 1'b0;
   localparam logic HTRANS_ACTIVE = 1'b1;

   function automatic arb_state_e own_state(input logic id);
      return (id == M2) ? OWN2 : OWN1;
   endfunction

endpackage

// File: rtl/ahb_arb_hold_cnt.sv
// Hold counter that limits bus tenure while the other master waits.
// Only instantiated when AHB_ARB_TIMEOUT_EN is defined.
module ahb_arb_hold_cnt
   import ahb_arb_pkg::*;
#(
   parameter int MAX_HOLD = 16,
   parameter int CNT_W    = 5
) (
   input  logic hclk,
   input  logic hresetn,
   input  logic hready,
   input  logic count_en,
   input  logic clear,
   output logic expired
);

   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_HOLD - 1);

   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clear || !count_en) begin
         cnt_d = '0;
      end else if (cnt_q != CNT_MAX) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   // Wait states freeze the count together with the rest of the arbiter.
   always_ff @(posedge hclk) begin
      if (!hresetn) begin
         cnt_q <= '0;
      end else if (hready) begin
         cnt_q <= cnt_d;
      end
   end

   assign expired = (cnt_q == CNT_MAX);

endmodule

// File: rtl/ahb_arbiter_2m.sv
// Two-master round-robin AHB arbiter tracking address- and data-phase bus owners.
// Optional forced handover after MAX_HOLD cycles: define AHB_ARB_TIMEOUT_EN.
//
// state | meaning
// IDLE  | no master granted
// OWN1  | master 1 owns the address phase
// OWN2  | master 2 owns the address phase
module ahb_arbiter_2m
   import ahb_arb_pkg::*;
#(
   parameter int MAX_HOLD = 16,
   parameter int CNT_W    = 5
) (
   input  logic hclk,
   input  logic hresetn,
   input  logic hbusreq1,
   input  logic hbusreq2,
   input  logic hready,
   input  logic htrans,
   output logic hgrant1,
   output logic hgrant2,
   output logic hmaster,
   output logic hmaster_data,
   output logic bus_owned
);

   if (MAX_HOLD < 2) begin : g_bad_max_hold
      $error("ahb_arbiter_2m: MAX_HOLD must be at least 2");
   end
   if ((1 << CNT_W) <= MAX_HOLD) begin : g_bad_cnt_w
      $error("ahb_arbiter_2m: CNT_W too narrow for MAX_HOLD");
   end

   arb_state_e state_q;
   arb_state_e state_d;
   logic       last_owner_q;
   logic       hgrant1_q;
   logic       hgrant2_q;
   logic       hmaster_q;
   logic       hmaster_data_q;
   logic       bus_owned_q;

   logic       own_req;
   logic       oth_req;
   logic       owning;
   logic       force_ho;

   always_comb begin
      own_req = 1'b0;
      oth_req = 1'b0;
      owning  = 1'b0;
      case (state_q)
         OWN1: begin
            own_req = hbusreq1;
            oth_req = hbusreq2;
            owning  = 1'b1;
         end
         OWN2: begin
            own_req = hbusreq2;
            oth_req = hbusreq1;
            owning  = 1'b1;
         end
         default: begin
            own_req = 1'b0;
            oth_req = 1'b0;
            owning  = 1'b0;
         end
      endcase
   end

`ifdef AHB_ARB_TIMEOUT_EN
   logic hold_expired;

   ahb_arb_hold_cnt #(
      .MAX_HOLD (MAX_HOLD),
      .CNT_W    (CNT_W)
   ) u_hold_cnt (
      .hclk     (hclk),
      .hresetn  (hresetn),
      .hready   (hready),
      .count_en (owning && oth_req),
      .clear    (state_d != state_q),
      .expired  (hold_expired)
   );

   assign force_ho = hold_expired && oth_req && (htrans == HTRANS_IDLE);
`else
   assign force_ho = 1'b0;
`endif

   always_comb begin
      state_d = state_q;
      if (hready) begin
         case (state_q)
            IDLE: begin
               if (hbusreq1 && hbusreq2) begin
                  state_d = own_state(~last_owner_q);
               end else if (hbusreq1) begin
                  state_d = OWN1;
               end else if (hbusreq2) begin
                  state_d = OWN2;
               end
            end
            OWN1, OWN2: begin
               // The owner is never pulled off the bus mid-burst (htrans active).
               if ((own_req && !force_ho) || (htrans == HTRANS_ACTIVE)) begin
                  state_d = state_q;
               end else if (oth_req) begin
                  state_d = (state_q == OWN1) ? OWN2 : OWN1;
               end else begin
                  state_d = IDLE;
               end
            end
            default: state_d = IDLE;
         endcase
      end
   end

   always_ff @(posedge hclk) begin
      if (!hresetn) begin
         state_q        <= IDLE;
         last_owner_q   <= M2;
         hgrant1_q      <= 1'b0;
         hgrant2_q      <= 1'b0;
         hmaster_q      <= M1;
         hmaster_data_q <= M1;
         bus_owned_q    <= 1'b0;
      end else if (hready) begin
         state_q        <= state_d;
         hgrant1_q      <= (state_d == OWN1);
         hgrant2_q      <= (state_d == OWN2);
         bus_owned_q    <= (state_d != IDLE);
         hmaster_data_q <= hmaster_q;
         // hmaster and last_owner are sticky through IDLE.
         if ((state_d != state_q) && (state_d != IDLE)) begin
            hmaster_q    <= (state_d == OWN2) ? M2 : M1;
            last_owner_q <= (state_d == OWN2) ? M2 : M1;
         end
      end
   end

   assign hgrant1      = hgrant1_q;
   assign hgrant2      = hgrant2_q;
   assign hmaster      = hmaster_q;
   assign hmaster_data = hmaster_data_q;
   assign bus_owned    = bus_owned_q;

endmodule
